// File: rtl/reflector_loader.sv
// Serial loader that packs a 26-letter reflector wiring, validates it as an involution and commits it.
// Define REFLECTOR_LOADER_FIXED_POINT_CHECK_EN to also reject letters wired to themselves (err_code 3).
module reflector_loader (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic         valid_i,
   input  logic [7:0]   din_i,
   output logic         ready_o,
   output logic [207:0] idx_out_o,
   output logic         set_o,
   output logic         busy_o,
   output logic         err_o,
   output logic [1:0]   err_code_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CHECK  = 3'd2,
      S_COMMIT = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   localparam logic [1:0] CODE_NONE    = 2'd0;
   localparam logic [1:0] CODE_ILLEGAL = 2'd1;
   localparam logic [1:0] CODE_NOT_INV = 2'd2;
   localparam logic [1:0] CODE_FIXED   = 2'd3;

   state_t       state_q, state_d;
   logic [7:0]   stage_q [26];
   logic [4:0]   cnt_q, cnt_d;
   logic [4:0]   ci_q, ci_d;
   logic         err_q, err_d;
   logic [1:0]   code_q, code_d;
   logic [207:0] idx_q;
   logic [207:0] packed_stage;
   logic         load_en;
   logic         commit_en;
   logic         letter_ok;
   logic [4:0]   m;
   logic [7:0]   exp_letter;
   logic         not_inv;
`ifdef REFLECTOR_LOADER_FIXED_POINT_CHECK_EN
   logic         fixed_pt;
`endif

   assign letter_ok = (din_i >= 8'h41) && (din_i <= 8'h5A);

   // Stored letters are validated, so the low five bits of 'A'..'Z' are 1..26.
   assign m          = stage_q[ci_q][4:0] - 5'd1;
   assign exp_letter = 8'h41 + {3'b000, ci_q};
   assign not_inv    = (stage_q[m] != exp_letter);
`ifdef REFLECTOR_LOADER_FIXED_POINT_CHECK_EN
   assign fixed_pt   = (m == ci_q);
`endif

   for (genvar gi = 0; gi < 26; gi++) begin : g_pack
      assign packed_stage[207-8*gi -: 8] = stage_q[gi];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ci_d      = ci_q;
      err_d     = err_q;
      code_d    = code_q;
      load_en   = 1'b0;
      commit_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LOAD;
               cnt_d   = 5'd0;
               err_d   = 1'b0;
               code_d  = CODE_NONE;
            end
         end
         S_LOAD: begin
            if (start_i) begin
               cnt_d = 5'd0;
            end else if (valid_i) begin
               if (letter_ok) begin
                  load_en = 1'b1;
                  cnt_d   = cnt_q + 5'd1;
                  if (cnt_q == 5'd25) begin
                     state_d = S_CHECK;
                     ci_d    = 5'd0;
                  end
               end else begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
                  code_d  = CODE_ILLEGAL;
               end
            end
         end
         S_CHECK: begin
            if (start_i) begin
               state_d = S_LOAD;
               cnt_d   = 5'd0;
`ifdef REFLECTOR_LOADER_FIXED_POINT_CHECK_EN
            end else if (fixed_pt) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
               code_d  = CODE_FIXED;
`endif
            end else if (not_inv) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
               code_d  = CODE_NOT_INV;
            end else if (ci_q == 5'd25) begin
               state_d   = S_COMMIT;
               commit_en = 1'b1;
            end else begin
               ci_d = ci_q + 5'd1;
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
         end
         S_ERROR: begin
            if (start_i) begin
               state_d = S_LOAD;
               cnt_d   = 5'd0;
               err_d   = 1'b0;
               code_d  = CODE_NONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      ready_o = (state_q == S_LOAD);
      busy_o  = (state_q == S_LOAD) || (state_q == S_CHECK) || (state_q == S_COMMIT);
      set_o   = (state_q == S_COMMIT);
   end

   // The committed table only moves on the edge that enters COMMIT, so set and table align.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q  <= 5'd0;
         ci_q   <= 5'd0;
         err_q  <= 1'b0;
         code_q <= CODE_NONE;
         idx_q  <= '0;
         for (int i = 0; i < 26; i++) begin
            stage_q[i] <= 8'd0;
         end
      end else begin
         cnt_q  <= cnt_d;
         ci_q   <= ci_d;
         err_q  <= err_d;
         code_q <= code_d;
         if (load_en) begin
            stage_q[cnt_q] <= din_i;
         end
         if (commit_en) begin
            idx_q <= packed_stage;
         end
      end
   end

   assign idx_out_o  = idx_q;
   assign err_o      = err_q;
   assign err_code_o = code_q;

endmodule

// File: tb/tb_reflector_loader.sv
// Randomized bench for reflector_loader: a phase-level model predicts every output each cycle.
module tb_reflector_loader;

   typedef logic [7:0] wiring_t [26];

   logic         clk = 1'b0;
   logic         rst;
   logic         start = 1'b0;
   logic         valid = 1'b0;
   logic [7:0]   din = 8'd0;
   logic         ready_o, set_o, busy_o, err_o;
   logic [207:0] idx_out_o;
   logic [1:0]   err_code_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_n = 0;
   int set_cnt = 0;
   int ready_cnt = 0;

   reflector_loader dut (
      .clk_i(clk), .reset_i(rst), .start_i(start), .valid_i(valid), .din_i(din),
      .ready_o(ready_o), .idx_out_o(idx_out_o), .set_o(set_o), .busy_o(busy_o),
      .err_o(err_o), .err_code_o(err_code_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;

   // Model: phase 0 idle, 1 collecting letters, 2 verdict pending, 3 commit pulse, 4 error
   int           m_ph = 0;
   logic [7:0]   m_stg [$];
   int           m_left = 0;
   logic [1:0]   m_verdict = 2'd0;
   logic [207:0] m_idx = '0;
   logic         m_err = 1'b0;
   logic [1:0]   m_code = 2'd0;

   // Verdict of a full wiring and how many check cycles until it is known.
   task automatic judge();
      m_verdict = 2'd0;
      m_left    = 26;
      for (int k = 0; k < 26; k++) begin
         int img;
         img = int'(m_stg[k]) - 65;
`ifdef REFLECTOR_LOADER_FIXED_POINT_CHECK_EN
         if (img == k) begin
            m_verdict = 2'd3;
            m_left    = k + 1;
            break;
         end
`endif
         if (int'(m_stg[img]) != 65 + k) begin
            m_verdict = 2'd2;
            m_left    = k + 1;
            break;
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = 0; m_stg.delete(); m_idx = '0; m_err = 1'b0; m_code = 2'd0;
      end else begin
         case (m_ph)
            0, 4: if (start) begin
               m_ph = 1; m_stg.delete(); m_err = 1'b0; m_code = 2'd0;
            end
            1: if (start) begin
               m_stg.delete();
            end else if (valid) begin
               if (din >= 8'h41 && din <= 8'h5A) begin
                  m_stg.push_back(din);
                  if (m_stg.size() == 26) begin
                     judge();
                     m_ph = 2;
                  end
               end else begin
                  m_ph = 4; m_err = 1'b1; m_code = 2'd1;
               end
            end
            2: if (start) begin
               m_ph = 1; m_stg.delete();
            end else begin
               m_left--;
               if (m_left == 0) begin
                  if (m_verdict == 2'd0) begin
                     m_ph = 3;
                     for (int i = 0; i < 26; i++) m_idx[207-8*i -: 8] = m_stg[i];
                  end else begin
                     m_ph = 4; m_err = 1'b1; m_code = m_verdict;
                  end
               end
            end
            default: m_ph = 0;
         endcase
      end
   end

   task automatic cmp(input string nm, input logic [207:0] act, input logic [207:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cmp("ready", 208'(ready_o), 208'(m_ph == 1));
      cmp("busy", 208'(busy_o), 208'(m_ph >= 1 && m_ph <= 3));
      cmp("set", 208'(set_o), 208'(m_ph == 3));
      cmp("err", 208'(err_o), 208'(m_err));
      cmp("err_code", 208'(err_code_o), 208'(m_code));
      cmp("idx_out", idx_out_o, m_idx);
      if (set_o === 1'b1) set_cnt++;
      if (ready_o === 1'b1) ready_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input wiring_t w, input int n, input bit gaps, output int hs_cyc);
      int i;
      i = 0;
      hs_cyc = cyc_n;
      while (i < n) begin
         valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         din = valid ? w[i] : 8'($urandom);
         hs_cyc = cyc_n;
         tick();
         if (valid) i++;
      end
      valid = 1'b0;
   endtask

   task automatic wait_done(output int at_cyc);
      at_cyc = -1;
      for (int t = 0; t < 60; t++) begin
         if (set_o || err_o) begin
            at_cyc = cyc_n;
            break;
         end
         tick();
      end
      if (at_cyc < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout: no set or err within 60 cycles, required one");
      end
   endtask

   function automatic wiring_t to_w(input string s);
      for (int i = 0; i < 26; i++) to_w[i] = s[i];
   endfunction

   function automatic wiring_t rand_reflector();
      int p [26];
      for (int i = 0; i < 26; i++) p[i] = i;
      for (int i = 25; i > 0; i--) begin
         int j, t;
         j = $urandom_range(0, i);
         t = p[i]; p[i] = p[j]; p[j] = t;
      end
      for (int j = 0; j < 13; j++) begin
         int a, b;
         a = p[2*j];
         b = p[2*j+1];
         if ($urandom_range(0, 5) == 0) begin
            rand_reflector[a] = 8'(65 + a);
            rand_reflector[b] = 8'(65 + b);
         end else begin
            rand_reflector[a] = 8'(65 + b);
            rand_reflector[b] = 8'(65 + a);
         end
      end
   endfunction

   initial begin
      wiring_t w, ww;
      int hs, done_at, sc0, rc0;
      logic [7:0] bad [6];
      bad[0] = 8'h40; bad[1] = 8'h5B; bad[2] = 8'h61; bad[3] = 8'h00; bad[4] = 8'hFF; bad[5] = 8'h30;

      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reflector B, valid held high
      w = to_w("YRUHQSLDPXNGOKMIEBFZCWVJAT");
      sc0 = set_cnt; rc0 = ready_cnt;
      pulse_start();
      send(w, 26, 1'b0, hs);
      wait_done(done_at);
      cmp("latency_27", 208'(done_at - hs), 208'(27));
      cmp("B_first", 208'(idx_out_o[207:200]), 208'(8'h59));
      cmp("B_last", 208'(idx_out_o[7:0]), 208'(8'h54));
      cmp("B_err", 208'(err_o), 208'(0));
      // A start during the commit cycle must be ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      cmp("B_ready_cycles", 208'(ready_cnt - rc0), 208'(26));
      cmp("B_one_set", 208'(set_cnt - sc0), 208'(1));

      // Illegal lowercase letter at index 5
      ww = w; ww[5] = 8'h61;
      sc0 = set_cnt;
      pulse_start();
      send(ww, 26, 1'b0, hs);
      tick();
      cmp("illegal_err", 208'(err_o), 208'(1));
      cmp("illegal_code", 208'(err_code_o), 208'(1));
      cmp("illegal_ready", 208'(ready_o), 208'(0));
      cmp("illegal_keep", 208'(idx_out_o[207:200]), 208'(8'h59));
      cmp("illegal_noset", 208'(set_cnt - sc0), 208'(0));

      // C maps to itself
      pulse_start();
      send(to_w("BACDEFGHIJKLMNOPQRSTUVWXYZ"), 26, 1'b0, hs);
      wait_done(done_at);
      tick();
`ifdef REFLECTOR_LOADER_FIXED_POINT_CHECK_EN
      cmp("fixed_code", 208'(err_code_o), 208'(3));
`else
      cmp("fixed_commit", 208'(idx_out_o[191:184]), 208'(8'h43));
`endif

      // Three-cycle A->B->C->A breaks the involution at index 0
      sc0 = set_cnt;
      pulse_start();
      send(to_w("BCADFEHGJILKNMPORQTSVUXWZY"), 26, 1'b0, hs);
      wait_done(done_at);
      tick();
      cmp("cycle_code", 208'(err_code_o), 208'(2));
      cmp("cycle_noset", 208'(set_cnt - sc0), 208'(0));

      // Restart after 10 letters
      sc0 = set_cnt;
      pulse_start();
      send(w, 10, 1'b0, hs);
      pulse_start();
      send(w, 26, 1'b0, hs);
      wait_done(done_at);
      tick(); tick();
      cmp("restart_one_set", 208'(set_cnt - sc0), 208'(1));

      // Reset during CHECK, then a clean load
      sc0 = set_cnt;
      pulse_start();
      send(rand_reflector(), 26, 1'b0, hs);
      repeat (5) tick();
      rst = 1'b1;
      #1;
      cmp("rst_idx", idx_out_o, 208'd0);
      cmp("rst_busy", 208'(busy_o), 208'(0));
      tick();
      rst = 1'b0;
      tick();
      cmp("rst_noset", 208'(set_cnt - sc0), 208'(0));
      pulse_start();
      send(w, 26, 1'b1, hs);
      wait_done(done_at);
      tick();
      cmp("rst_then_commit", 208'(set_cnt - sc0), 208'(1));

      // Randomized loads: valid reflectors, broken ones, illegal bytes, restarts
      for (int it = 0; it < 16; it++) begin
         int kind;
         kind = $urandom_range(0, 3);
         ww = rand_reflector();
         if (kind == 1) begin
            int a, b;
            logic [7:0] t;
            a = $urandom_range(0, 25);
            b = $urandom_range(0, 25);
            t = ww[a]; ww[a] = ww[b]; ww[b] = t;
         end else if (kind == 2) begin
            ww[$urandom_range(0, 25)] = bad[$urandom_range(0, 5)];
         end
         pulse_start();
         if (kind == 3) begin
            send(rand_reflector(), $urandom_range(1, 25), 1'b1, hs);
            pulse_start();
         end
         send(ww, 26, 1'b1, hs);
         wait_done(done_at);
         repeat ($urandom_range(1, 3)) tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
